button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/pype_btn_pkg.sv | 21 ++
 rtl/btn_debounce_ch.sv | 109 ++++++++++
 rtl/button_conditioner.sv | 42 ++++
 tb/tb_button_conditioner.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pype_btn_pkg.sv
// Shared button indices and helpers for the pype board (tilesort, mojo_top, button_conditioner).
// rep_phase_e and maxInt are used only when BTN_AUTOREPEAT_EN is defined.
package pype_btn_pkg;

  localparam int NUM_BTN    = 5;
  localparam int BTN_UP     = 0;
  localparam int BTN_CENTER = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_RIGHT  = 4;

  typedef enum logic {
    REP_DELAY  = 1'b0,
    REP_PERIOD = 1'b1
  } rep_phase_e;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, saturating debounce counter and press pulse.
// Auto-repeat hold counter exists only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import pype_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  logic w_differ;
  logic w_accept;
  logic w_rise;
  logic w_repeat;

  assign w_differ = (r_sync2 != r_level);
  assign w_accept = w_differ && (r_cnt == CNT_LAST);
  assign w_rise   = w_accept && !r_level;

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_press <= w_rise || w_repeat;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(maxInt(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX    = '1;

  rep_phase_e        r_phase;
  rep_phase_e        w_phaseNext;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_holdNext;
  logic [HOLD_W-1:0] w_holdTarget;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= REP_DELAY;
      r_hold  <= '0;
    end else begin
      r_phase <= w_phaseNext;
      r_hold  <= w_holdNext;
    end
  end

  // The hold counter restarts on the initial press edge, so a repeat can never land on it.
  always_comb begin
    w_phaseNext  = r_phase;
    w_holdNext   = r_hold;
    w_repeat     = 1'b0;
    w_holdTarget = (r_phase == REP_DELAY) ? DELAY_LAST : PERIOD_LAST;
    if (!REPEAT_EN || !r_level || w_accept) begin
      w_phaseNext = REP_DELAY;
      w_holdNext  = '0;
    end else if (r_hold == w_holdTarget) begin
      w_repeat    = 1'b1;
      w_phaseNext = REP_PERIOD;
      w_holdNext  = '0;
    end else if (r_hold != HOLD_MAX) begin
      w_holdNext = r_hold + 1'b1;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the five pype board buttons and emits one-cycle press pulses per channel.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat on the channels set in REPEAT_MASK.
module button_conditioner
  import pype_btn_pkg::*;
#(
  parameter int                 DEBOUNCE_CYCLES = 1000000,
  parameter int                 REPEAT_DELAY    = 25000000,
  parameter int                 REPEAT_PERIOD   = 5000000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b11101
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] io_button,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press
);

  // Repeat timing only reaches the channels in the auto-repeat build; this empty
  // guard keeps every configuration parameter referenced in both builds.
  if ((DEBOUNCE_CYCLES < 1) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1) ||
      ($bits(REPEAT_MASK) != NUM_BTN)) begin : g_badConfig
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_EN      (REPEAT_MASK[g]),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (io_button[g]),
      .o_level(btn_level[g]),
      .o_press(btn_press[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table, hand sequences and randomized run against a window model.
// Repeat expectations follow BTN_AUTOREPEAT_EN when the bench is compiled with it.
module tb_button_conditioner;

  localparam int          DEB    = 4;
  localparam int          DELAY  = 10;
  localparam int          PERIOD = 3;
  localparam logic [4:0]  MASK   = 5'b11101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] io_button = 5'd0;
  logic [4:0] btn_level;
  logic [4:0] btn_press;

  int checkCount = 0;
  int errCount   = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DELAY),
    .REPEAT_PERIOD  (PERIOD),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_button(io_button),
    .btn_level(btn_level),
    .btn_press(btn_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] btn;
    logic [4:0] expLevel;
    logic [4:0] expPress;
  } vec_t;

  vec_t vecs[$];

  // Reference model: raw samples pass a two-deep delay, and a channel flips once the
  // last DEB delayed samples all disagree with its level.
  logic [4:0] rawPipe[$];
  logic [4:0] winQ[$];
  logic [4:0] mLevel = '0;
  logic [4:0] mPress = '0;
  int         mAge[5];

  task automatic modelStep(input logic r, input logic [4:0] b);
    logic [4:0] s2;
    logic [4:0] newLevel;
    bit         flip;
    if (r) begin
      rawPipe.delete();
      rawPipe.push_back(5'd0);
      rawPipe.push_back(5'd0);
      winQ.delete();
      mLevel = '0;
      mPress = '0;
      for (int i = 0; i < 5; i++) mAge[i] = 0;
      return;
    end
    s2 = rawPipe.pop_front();
    rawPipe.push_back(b);
    winQ.push_back(s2);
    if (winQ.size() > DEB) void'(winQ.pop_front());
    newLevel = mLevel;
    mPress   = '0;
    for (int i = 0; i < 5; i++) begin
      flip = (winQ.size() == DEB);
      for (int j = 0; j < winQ.size(); j++)
        if (winQ[j][i] == mLevel[i]) flip = 0;
      if (flip) begin
        newLevel[i] = ~mLevel[i];
        if (newLevel[i]) begin
          mPress[i] = 1'b1;
          mAge[i]   = 0;
        end
      end else if (mLevel[i]) begin
        mAge[i]++;
`ifdef BTN_AUTOREPEAT_EN
        if (MASK[i] && mAge[i] >= DELAY && ((mAge[i] - DELAY) % PERIOD) == 0)
          mPress[i] = 1'b1;
`endif
      end
    end
    mLevel = newLevel;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] b);
    rst       = r;
    io_button = b;
    @(posedge clk);
    #1;
    modelStep(r, b);
    checkOutput("model_level", btn_level, mLevel);
    checkOutput("model_press", btn_press, mPress);
  endtask

  task automatic addRun(input logic r, input logic [4:0] b, input logic [4:0] lvl,
                        input logic [4:0] prs, input int n);
    vec_t v;
    v.rst = r; v.btn = b; v.expLevel = lvl; v.expPress = prs;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  int pulses0[$];
  int pulses1[$];
  int pulses4[$];
  int expPulses[$];

  initial begin
    rawPipe.push_back(5'd0);
    rawPipe.push_back(5'd0);
    for (int i = 0; i < 5; i++) mAge[i] = 0;

    // Row 0 is the reset edge; a button driven after edge N is first sampled at edge N+1.
    addRun(1'b1, 5'b00000, 5'b00000, 5'b00000, 1);
    addRun(1'b0, 5'b00001, 5'b00000, 5'b00000, 5);
    addRun(1'b0, 5'b00001, 5'b00001, 5'b00001, 1);
    addRun(1'b0, 5'b00001, 5'b00001, 5'b00000, 1);
    addRun(1'b0, 5'b00000, 5'b00001, 5'b00000, 5);
    addRun(1'b0, 5'b00000, 5'b00000, 5'b00000, 2);
    addRun(1'b0, 5'b01000, 5'b00000, 5'b00000, 3);
    addRun(1'b0, 5'b00000, 5'b00000, 5'b00000, 8);
    addRun(1'b0, 5'b10100, 5'b00000, 5'b00000, 5);
    addRun(1'b0, 5'b10100, 5'b10100, 5'b10100, 1);
    addRun(1'b0, 5'b10100, 5'b10100, 5'b00000, 2);
    addRun(1'b0, 5'b00000, 5'b10100, 5'b00000, 5);
    addRun(1'b0, 5'b00000, 5'b00000, 5'b00000, 2);

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].rst, vecs[k].btn);
      checkOutput($sformatf("vec%0d_level", k), btn_level, vecs[k].expLevel);
      checkOutput($sformatf("vec%0d_press", k), btn_press, vecs[k].expPress);
    end

    // Hold up and center for 40 edges: center never repeats, up repeats only when enabled.
    applyStimulus(1'b1, 5'b00000);
    for (int s = 1; s <= 40; s++) begin
      applyStimulus(1'b0, 5'b00011);
      if (btn_press[0]) pulses0.push_back(s);
      if (btn_press[1]) pulses1.push_back(s);
    end
`ifdef BTN_AUTOREPEAT_EN
    expPulses = '{6, 16, 19, 22, 25, 28, 31, 34, 37, 40};
`else
    expPulses = '{6};
`endif
    checkOutput("hold_up_pulse_count", pulses0.size(), expPulses.size());
    for (int k = 0; k < expPulses.size() && k < pulses0.size(); k++)
      checkOutput($sformatf("hold_up_pulse%0d_edge", k), pulses0[k], expPulses[k]);
    checkOutput("hold_center_pulse_count", pulses1.size(), 1);
    checkOutput("hold_center_pulse_edge", (pulses1.size() > 0) ? pulses1[0] : -1, 6);
    for (int s = 0; s < 10; s++) applyStimulus(1'b0, 5'b00000);

    // Reset lands mid-debounce on a held right button; it must re-debounce from scratch.
    applyStimulus(1'b1, 5'b00000);
    for (int s = 1; s <= 3; s++) applyStimulus(1'b0, 5'b10000);
    applyStimulus(1'b1, 5'b10000);
    checkOutput("rst_mid_level", btn_level, 5'b00000);
    checkOutput("rst_mid_press", btn_press, 5'b00000);
    for (int s = 5; s <= 20; s++) begin
      applyStimulus(1'b0, 5'b10000);
      if (btn_press[4]) pulses4.push_back(s);
    end
    checkOutput("rst_held_pulse_count", pulses4.size(), 1);
    checkOutput("rst_held_pulse_edge", (pulses4.size() > 0) ? pulses4[0] : -1, 10);
    for (int s = 0; s < 10; s++) applyStimulus(1'b0, 5'b00000);

    for (int chunk = 0; chunk < 80; chunk++) begin
      logic       r;
      logic [4:0] b;
      int         len;
      r   = ($urandom_range(0, 19) == 0);
      b   = 5'($urandom_range(0, 31));
      len = r ? 1 : (($urandom_range(0, 4) == 0) ? $urandom_range(15, 30)
                                                  : $urandom_range(1, 8));
      for (int s = 0; s < len; s++) applyStimulus(r, b);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
